// File: rtl/lcd_cmd_arbiter.sv
// lcd_cmd_arbiter: shares the LCD controller's host byte port between two requesters.
// Bursts lock the port to their owner; every byte runs start/done and a settle delay.
module lcd_cmd_arbiter #(
  parameter int DLY_CYCLES = 16382,
  parameter int DLY_W      = 18
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iREQ0_VALID,
  input  logic [8:0] iREQ0_DATA,
  input  logic       iREQ0_LAST,
  output logic       oREQ0_ACK,
  input  logic       iREQ1_VALID,
  input  logic [8:0] iREQ1_DATA,
  input  logic       iREQ1_LAST,
  output logic       oREQ1_ACK,
  output logic [7:0] oLCD_DATA,
  output logic       oLCD_RS,
  output logic       oLCD_START,
  input  logic       iLCD_DONE,
  output logic [1:0] oGRANT,
  output logic       oBUSY
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_SETTLE    = 2'd3
  } state_t;

  // A zero delay still spends one cycle in SETTLE.
  localparam logic [DLY_W-1:0] LP_CNT_LAST =
    (DLY_CYCLES == 0) ? {DLY_W{1'b0}} : DLY_W'(DLY_CYCLES - 1);

  state_t           r_state;
  logic             r_lock;
  logic             r_owner;
  logic             r_last_grant;
  logic [DLY_W-1:0] r_cnt;
  logic             r_ack0;
  logic             r_ack1;
  logic [7:0]       r_lcd_data;
  logic             r_lcd_rs;
  logic             r_start;
  logic [1:0]       r_grant;
  logic             r_busy;

  logic             w_win_valid;
  logic             w_win_sel;
  logic [8:0]       w_win_data;
  logic             w_win_last;
  logic             w_settle_done;

  // Winner selection: a locked owner excludes the other side, otherwise round robin on ties.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_sel   = 1'b0;
    if (r_lock) begin
      w_win_sel   = r_owner;
      w_win_valid = r_owner ? iREQ1_VALID : iREQ0_VALID;
    end else if (iREQ0_VALID && iREQ1_VALID) begin
      w_win_valid = 1'b1;
      w_win_sel   = ~r_last_grant;
    end else if (iREQ0_VALID || iREQ1_VALID) begin
      w_win_valid = 1'b1;
      w_win_sel   = iREQ1_VALID;
    end else begin
      w_win_valid = 1'b0;
      w_win_sel   = 1'b0;
    end
  end

  assign w_win_data    = w_win_sel ? iREQ1_DATA : iREQ0_DATA;
  assign w_win_last    = w_win_sel ? iREQ1_LAST : iREQ0_LAST;
  assign w_settle_done = (DLY_CYCLES == 0) || (r_cnt == LP_CNT_LAST);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state      <= ST_IDLE;
      r_lock       <= 1'b0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= {DLY_W{1'b0}};
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_lcd_data   <= 8'h00;
      r_lcd_rs     <= 1'b0;
      r_start      <= 1'b0;
      r_grant      <= 2'b00;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_win_valid) begin
            r_lcd_data   <= w_win_data[7:0];
            r_lcd_rs     <= w_win_data[8];
            r_ack0       <= ~w_win_sel;
            r_ack1       <= w_win_sel;
            r_grant      <= w_win_sel ? 2'b10 : 2'b01;
            r_owner      <= w_win_sel;
            r_last_grant <= w_win_sel;
            r_lock       <= ~w_win_last;
            r_busy       <= 1'b1;
            r_state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_start <= 1'b1;
          r_state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (iLCD_DONE) begin
            r_start <= 1'b0;
            r_cnt   <= {DLY_W{1'b0}};
            r_state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          r_cnt <= r_cnt + DLY_W'(1);
          // The grant survives into IDLE only while a burst is still locked.
          if (w_settle_done) begin
            r_state <= ST_IDLE;
            r_busy  <= r_lock;
            if (!r_lock) begin
              r_grant <= 2'b00;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign oREQ0_ACK  = r_ack0;
  assign oREQ1_ACK  = r_ack1;
  assign oLCD_DATA  = r_lcd_data;
  assign oLCD_RS    = r_lcd_rs;
  assign oLCD_START = r_start;
  assign oGRANT     = r_grant;
  assign oBUSY      = r_busy;

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Bench for lcd_cmd_arbiter: directed scenarios and random bursts, checked every cycle
// against an event-level model of the arbitration, handshake and settle timing rules.
module tb_lcd_cmd_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0, done = 1'b0;
  logic [8:0] d0 = 9'h000, d1 = 9'h000;

  logic       a_ack0, a_ack1, a_rs, a_start, a_busy;
  logic [7:0] a_data;
  logic [1:0] a_grant;
  logic       b_ack0, b_ack1, b_rs, b_start, b_busy;
  logic [7:0] b_data;
  logic [1:0] b_grant;

  int vec = 0;
  int err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_cmd_arbiter #(.DLY_CYCLES(4), .DLY_W(18)) u_dut_a (
    .iCLK(clk), .iRST(rst),
    .iREQ0_VALID(v0 & ~sel), .iREQ0_DATA(d0), .iREQ0_LAST(l0), .oREQ0_ACK(a_ack0),
    .iREQ1_VALID(v1 & ~sel), .iREQ1_DATA(d1), .iREQ1_LAST(l1), .oREQ1_ACK(a_ack1),
    .oLCD_DATA(a_data), .oLCD_RS(a_rs), .oLCD_START(a_start), .iLCD_DONE(done & ~sel),
    .oGRANT(a_grant), .oBUSY(a_busy)
  );

  lcd_cmd_arbiter #(.DLY_CYCLES(0), .DLY_W(4)) u_dut_b (
    .iCLK(clk), .iRST(rst),
    .iREQ0_VALID(v0 & sel), .iREQ0_DATA(d0), .iREQ0_LAST(l0), .oREQ0_ACK(b_ack0),
    .iREQ1_VALID(v1 & sel), .iREQ1_DATA(d1), .iREQ1_LAST(l1), .oREQ1_ACK(b_ack1),
    .oLCD_DATA(b_data), .oLCD_RS(b_rs), .oLCD_START(b_start), .iLCD_DONE(done & sel),
    .oGRANT(b_grant), .oBUSY(b_busy)
  );

  logic       m_ack0, m_ack1, m_rs, m_start, m_busy;
  logic [7:0] m_data;
  logic [1:0] m_grant;
  assign m_ack0  = sel ? b_ack0  : a_ack0;
  assign m_ack1  = sel ? b_ack1  : a_ack1;
  assign m_rs    = sel ? b_rs    : a_rs;
  assign m_start = sel ? b_start : a_start;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_data  = sel ? b_data  : a_data;
  assign m_grant = sel ? b_grant : a_grant;

  // Requester queues hold {LAST, RS, byte}; the head is presented until ACKed.
  logic [9:0] q0[$];
  logic [9:0] q1[$];

  // Observed accepts, done edges and pulse widths.
  int         log_req[$];
  logic [8:0] log_dat[$];
  int         log_acc[$];
  int         log_done[$];
  int         start_run = 0, start_len_last = 0, grant_fall = 0;
  logic       prev_start = 1'b0;
  logic [1:0] prev_grant = 2'b00;

  // Reference model state.
  bit         mon_en = 1'b0;
  bit         md_lock, md_owner, md_last, inflight, d_known, win_ok, win;
  int         acc, idle_at, s_len;
  logic [1:0] grant_exp;
  logic [8:0] data_exp;
  logic       start_exp, busy_exp, ea0, ea1;

  int         lcd_cnt = 0, dd = 3;
  bit         rand_dd = 1'b0, spur = 1'b0;

  // Per-cycle model check, then requester and LCD-controller behaviour.
  always @(negedge clk) begin
    s_len = sel ? 1 : 4;
    if (rst) begin
      mon_en = 1'b1;
      vec++;
      if ({m_ack0, m_ack1, m_start, m_grant, m_busy, m_rs, m_data} !== 15'd0) begin
        err++;
        $display("FAIL reset_outputs cyc=%0d got=%b want=0", cyc,
                 {m_ack0, m_ack1, m_start, m_grant, m_busy, m_rs, m_data});
      end
      md_lock = 1'b0; md_owner = 1'b0; md_last = 1'b1;
      inflight = 1'b0; d_known = 1'b0; idle_at = cyc;
      grant_exp = 2'b00; data_exp = 9'h000;
    end else if (mon_en) begin
      if (inflight && d_known && cyc == idle_at) begin
        inflight = 1'b0;
        if (!md_lock) grant_exp = 2'b00;
      end
      if (inflight && !d_known && cyc >= acc + 2 && done) begin
        d_known = 1'b1;
        idle_at = cyc + s_len;
      end
      ea0 = 1'b0; ea1 = 1'b0;
      if (!inflight && cyc >= idle_at + 1) begin
        win_ok = 1'b0; win = 1'b0;
        if (md_lock) begin
          win = md_owner; win_ok = md_owner ? v1 : v0;
        end else if (v0 && v1) begin
          win_ok = 1'b1; win = ~md_last;
        end else if (v0 || v1) begin
          win_ok = 1'b1; win = v1;
        end
        if (win_ok) begin
          ea0 = ~win; ea1 = win;
          inflight = 1'b1; acc = cyc; d_known = 1'b0;
          md_lock = win ? ~l1 : ~l0;
          md_owner = win; md_last = win;
          grant_exp = win ? 2'b10 : 2'b01;
          data_exp = win ? d1 : d0;
        end
      end
      start_exp = inflight && !d_known && (cyc >= acc + 1);
      busy_exp  = inflight || md_lock;
      vec++;
      if ({m_ack0, m_ack1} !== {ea0, ea1}) begin
        err++; $display("FAIL ack cyc=%0d got=%b want=%b", cyc, {m_ack0, m_ack1}, {ea0, ea1});
      end
      vec++;
      if (m_start !== start_exp) begin
        err++; $display("FAIL start cyc=%0d got=%b want=%b", cyc, m_start, start_exp);
      end
      vec++;
      if (m_grant !== grant_exp) begin
        err++; $display("FAIL grant cyc=%0d got=%b want=%b", cyc, m_grant, grant_exp);
      end
      vec++;
      if (m_busy !== busy_exp) begin
        err++; $display("FAIL busy cyc=%0d got=%b want=%b", cyc, m_busy, busy_exp);
      end
      vec++;
      if ({m_rs, m_data} !== data_exp) begin
        err++; $display("FAIL lcd_data cyc=%0d got=%h want=%h", cyc, {m_rs, m_data}, data_exp);
      end
      if (m_ack0 || m_ack1) begin
        log_req.push_back(m_ack1 ? 1 : 0);
        log_dat.push_back({m_rs, m_data});
        log_acc.push_back(cyc);
      end
      if (m_start) start_run++;
      else begin
        if (prev_start) begin
          start_len_last = start_run;
          log_done.push_back(cyc);
        end
        start_run = 0;
      end
      if (prev_grant != 2'b00 && m_grant == 2'b00) grant_fall = cyc;
    end
    if (rst) start_run = 0;
    prev_start = m_start;
    prev_grant = m_grant;

    if (m_ack0 && q0.size() > 0) q0.delete(0);
    if (m_ack1 && q1.size() > 0) q1.delete(0);
    v0 = (q0.size() > 0);
    v1 = (q1.size() > 0);
    if (v0) {l0, d0} = q0[0];
    if (v1) {l1, d1} = q1[0];

    if (done) done = 1'b0;
    else if (m_start) begin
      lcd_cnt++;
      if (lcd_cnt >= dd) begin
        done = 1'b1; lcd_cnt = 0;
        if (rand_dd) dd = $urandom_range(1, 5);
      end
    end else lcd_cnt = 0;
    if (rst) begin
      done = 1'b0; lcd_cnt = 0;
    end
    if (spur) begin
      done = 1'b1; spur = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    log_req.delete(); log_dat.delete(); log_acc.delete(); log_done.delete();
  endtask

  task automatic do_reset(input logic s);
    @(negedge clk); #1;
    rst = 1'b1; sel = s;
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk); #1;
      if (q0.size() == 0 && q1.size() == 0 && !v0 && !v1 && m_busy === 1'b0 && m_start === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    vec++;
    if (m_start !== 1'b0 || m_grant !== 2'b00 || m_busy !== 1'b0 || m_ack0 !== 1'b0 || m_ack1 !== 1'b0) begin
      err++; $display("FAIL reset_hold got start=%b grant=%b busy=%b want all 0", m_start, m_grant, m_busy);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk); #1;
    vec++;
    if (m_busy !== 1'b0 || m_grant !== 2'b00 || m_data !== 8'h00) begin
      err++; $display("FAIL reset_release got busy=%b grant=%b data=%h want 0", m_busy, m_grant, m_data);
    end
  endtask

  task automatic test_single();
    bit ok;
    clear_logs(); dd = 3; rand_dd = 1'b0;
    tick();
    q0.push_back({1'b1, 9'h138});
    wait_idle(100, ok);
    vec++;
    if (!ok) begin err++; $display("FAIL single_timeout got busy=%b want 0", m_busy); end
    vec++;
    if (log_req.size() != 1 || log_req[0] != 0 || log_dat[0] !== 9'h138) begin
      err++; $display("FAIL single_accept got n=%0d want one req0 ACK of 138", log_req.size());
    end
    vec++;
    if (start_len_last != 3) begin
      err++; $display("FAIL single_start_len got %0d want 3", start_len_last);
    end
    vec++;
    if (log_done.size() != 1 || grant_fall - log_done[0] != 4) begin
      err++; $display("FAIL single_grant_hold got %0d want 4", grant_fall - (log_done.size() > 0 ? log_done[0] : 0));
    end
    vec++;
    if (m_data !== 8'h38 || m_rs !== 1'b1 || m_grant !== 2'b00) begin
      err++; $display("FAIL single_final got data=%h rs=%b grant=%b want 38 1 00", m_data, m_rs, m_grant);
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    int         exp_req[4];
    logic [8:0] exp_dat[4];
    exp_req = '{0, 1, 0, 1};
    exp_dat = '{9'h031, 9'h1A1, 9'h032, 9'h1A2};
    do_reset(1'b0);
    clear_logs(); rand_dd = 1'b1;
    tick();
    q0.push_back({1'b1, 9'h031}); q0.push_back({1'b1, 9'h032});
    q1.push_back({1'b1, 9'h1A1}); q1.push_back({1'b1, 9'h1A2});
    wait_idle(400, ok);
    vec++;
    if (!ok || log_req.size() != 4) begin
      err++; $display("FAIL simul_count got %0d want 4", log_req.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vec++;
        if (log_req[i] != exp_req[i] || log_dat[i] !== exp_dat[i]) begin
          err++; $display("FAIL simul_order idx=%0d got req%0d %h want req%0d %h",
                          i, log_req[i], log_dat[i], exp_req[i], exp_dat[i]);
        end
      end
    end
  endtask

  task automatic test_burst_lock();
    bit ok;
    int exp_req[5];
    exp_req = '{0, 0, 0, 1, 1};
    clear_logs(); rand_dd = 1'b0; dd = 3;
    tick();
    q1.push_back({1'b1, 9'h1B0}); q1.push_back({1'b1, 9'h1B1});
    q0.push_back({1'b0, 9'h080}); q0.push_back({1'b0, 9'h141}); q0.push_back({1'b1, 9'h16C});
    wait_idle(400, ok);
    vec++;
    if (!ok || log_req.size() != 5 || log_done.size() != 5) begin
      err++; $display("FAIL burst_count got %0d want 5", log_req.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        vec++;
        if (log_req[i] != exp_req[i]) begin
          err++; $display("FAIL burst_order idx=%0d got req%0d want req%0d", i, log_req[i], exp_req[i]);
        end
      end
      vec++;
      if (log_dat[2] !== 9'h16C || log_acc[1] - log_done[0] != 5 || log_acc[3] - log_done[2] != 5) begin
        err++; $display("FAIL burst_timing got gap=%0d/%0d data=%h want 5/5 16c",
                        log_acc[1] - log_done[0], log_acc[3] - log_done[2], log_dat[2]);
      end
    end
  endtask

  task automatic test_locked_stall();
    bit ok;
    int busy_low;
    clear_logs(); busy_low = 0;
    tick();
    q0.push_back({1'b0, 9'h0C0});
    for (int i = 0; i < 20 && log_req.size() == 0; i++) tick();
    tick();
    q1.push_back({1'b1, 9'h131});
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (m_busy !== 1'b1) busy_low++;
    end
    vec++;
    if (busy_low != 0 || log_req.size() != 1) begin
      err++; $display("FAIL stall_hold got busy_low=%0d accepts=%0d want 0 1", busy_low, log_req.size());
    end
    tick();
    q0.push_back({1'b1, 9'h14F});
    wait_idle(200, ok);
    vec++;
    if (!ok || log_req.size() != 3 || log_req[1] != 0 || log_dat[1] !== 9'h14F || log_req[2] != 1) begin
      err++; $display("FAIL stall_resume got n=%0d want req0,req0,req1", log_req.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs(); dd = 20;
    tick();
    q0.push_back({1'b0, 9'h1FF});
    for (int i = 0; i < 20 && m_start !== 1'b1; i++) tick();
    tick();
    q1.push_back({1'b1, 9'h055});
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    vec++;
    if (m_start !== 1'b0) begin err++; $display("FAIL rstmid_start got %b want 0", m_start); end
    vec++;
    if (m_grant !== 2'b00) begin err++; $display("FAIL rstmid_grant got %b want 00", m_grant); end
    vec++;
    if (m_ack0 !== 1'b0 || m_ack1 !== 1'b0) begin
      err++; $display("FAIL rstmid_ack got %b%b want 00", m_ack0, m_ack1);
    end
    vec++;
    if (m_busy !== 1'b0) begin err++; $display("FAIL rstmid_busy got %b want 0", m_busy); end
    rst = 1'b0; dd = 3;
    wait_idle(200, ok);
    vec++;
    if (!ok || log_req.size() != 2 || log_req[1] != 1 || log_dat[1] !== 9'h055) begin
      err++; $display("FAIL rstmid_resume got n=%0d want req1 served after reset", log_req.size());
    end
  endtask

  task automatic test_dly0_spurious();
    bit ok;
    int bad;
    do_reset(1'b1);
    clear_logs(); dd = 2; bad = 0;
    tick();
    spur = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (m_start !== 1'b0 || m_busy !== 1'b0 || m_grant !== 2'b00) bad++;
    end
    vec++;
    if (bad != 0) begin err++; $display("FAIL spurious_done got %0d active cycles want 0", bad); end
    tick();
    q0.push_back({1'b1, 9'h101}); q0.push_back({1'b1, 9'h102}); q0.push_back({1'b1, 9'h103});
    wait_idle(200, ok);
    vec++;
    if (!ok || log_acc.size() != 3 || log_done.size() != 3) begin
      err++; $display("FAIL dly0_count got %0d want 3", log_acc.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        vec++;
        if (log_acc[i] - log_done[i-1] != 2) begin
          err++; $display("FAIL dly0_gap idx=%0d got %0d want 2", i, log_acc[i] - log_done[i-1]);
        end
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [8:0] exp0[$];
    logic [8:0] exp1[$];
    logic [8:0] rd;
    int r, len;
    do_reset(1'b0);
    clear_logs(); rand_dd = 1'b1;
    for (int it = 0; it < 25; it++) begin
      tick();
      r = $urandom_range(0, 1);
      len = $urandom_range(1, 3);
      for (int k = 0; k < len; k++) begin
        rd = 9'($urandom);
        if (r == 0) begin q0.push_back({k == len - 1, rd}); exp0.push_back(rd); end
        else begin q1.push_back({k == len - 1, rd}); exp1.push_back(rd); end
      end
      repeat ($urandom_range(0, 8)) tick();
    end
    wait_idle(5000, ok);
    vec++;
    if (!ok) begin err++; $display("FAIL random_timeout got busy=%b want 0", m_busy); end
    for (int i = 0; i < log_req.size(); i++) begin
      vec++;
      if (log_req[i] == 0 && exp0.size() > 0 && log_dat[i] === exp0[0]) exp0.delete(0);
      else if (log_req[i] == 1 && exp1.size() > 0 && log_dat[i] === exp1[0]) exp1.delete(0);
      else begin
        err++; $display("FAIL random_data idx=%0d got req%0d %h want next queued byte", i, log_req[i], log_dat[i]);
      end
    end
    vec++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      err++; $display("FAIL random_left got %0d/%0d unsent want 0/0", exp0.size(), exp1.size());
    end
    rand_dd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_burst_lock();
    test_locked_stall();
    test_reset_mid();
    test_dly0_spurious();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish want finish before cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
